fmul_arbiter: RTL and testbench

- Shares one FMUL32 instance between NUM_REQ independent requesters.
- Uses round-robin arbitration with a valid/ready issue handshake per requester.
- Registers the winning operands into FMUL32 and tracks in-flight operations with a tag pipeline.
- Routes each result, with FMUL32's val flag, back to the requester that issued it.

---
 rtl/fmul_arbiter.sv | 95 +++++++++
 tb/tb_fmul_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin front end that shares one pipelined FMUL32 between NUM_REQ requesters.
// Winning operands are registered into the multiplier; a tag pipeline routes each result back.
module fmul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int FMUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*2-1:0]   req_opc,
  input  logic [NUM_REQ*2-1:0]   req_rmode,
  output logic [DATA_W-1:0]      fm_op1,
  output logic [DATA_W-1:0]      fm_op2,
  output logic [1:0]             fm_opc,
  output logic [1:0]             fm_rmode,
  input  logic [DATA_W-1:0]      fm_result,
  input  logic                   fm_val,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_val,
  output logic                   busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One stage more than FMUL_LAT: the fm_* register itself is the first pipeline step,
  // so the last tag stage lines up with a settled fm_result.
  localparam int NST = FMUL_LAT + 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           grant_any;
  logic [NST-1:0] tag_vld;
  logic [IDW-1:0] tag_id [NST];

  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_any = 1'b0;
    k         = 0;
    if (en && rst_n) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        k = (32'(ptr) + j) % NUM_REQ;
        if (!grant_any && req_valid[k]) begin
          grant     = IDW'(k);
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      tag_vld    <= '0;
      for (int unsigned s = 0; s < NST; s++) tag_id[s] <= '0;
      fm_op1     <= '0;
      fm_op2     <= '0;
      fm_opc     <= '0;
      fm_rmode   <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_val    <= 1'b0;
    end else begin
      if (grant_any) begin
        fm_op1   <= req_op1[grant*DATA_W +: DATA_W];
        fm_op2   <= req_op2[grant*DATA_W +: DATA_W];
        fm_opc   <= req_opc[grant*2 +: 2];
        fm_rmode <= req_rmode[grant*2 +: 2];
        ptr      <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
      tag_vld   <= {tag_vld[NST-2:0], grant_any};
      tag_id[0] <= grant;
      for (int unsigned s = 1; s < NST; s++) tag_id[s] <= tag_id[s-1];
      rsp_valid <= '0;
      if (tag_vld[NST-1]) begin
        rsp_valid[tag_id[NST-1]] <= 1'b1;
        rsp_result <= fm_result;
        rsp_val    <= fm_val;
      end
    end
  end

  assign busy = (|tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: two instances (FMUL_LAT 2 and 4) share stimulus and are checked
// every cycle against an issue log indexed by clock edge, with a bench-side FMUL32 stand-in.
module tb_fmul_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int NL   = 2;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_op1 = '0, req_op2 = '0;
  logic [N*2-1:0] req_opc = '0, req_rmode = '0;

  logic [N-1:0] ready [NL];
  logic [N-1:0] rsp_valid [NL];
  logic [W-1:0] fm_op1 [NL], fm_op2 [NL], fm_result [NL], rsp_result [NL];
  logic [1:0]   fm_opc [NL], fm_rmode [NL];
  logic         fm_val [NL], rsp_val [NL], busy [NL];

  initial forever #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands; opc/rmode are folded into
  // the low bits so that their passthrough is visible in the result.
  function automatic logic [W-1:0] fmul_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] c, input logic [1:0] r);
    logic [47:0] m;
    logic [22:0] f;
    int e;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e++;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], 8'(e), f} ^ {28'd0, c, r};
  endfunction

  for (genvar k = 0; k < NL; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : 4;
    logic [W-1:0] pr [L];
    logic         pv [L];

    fmul_arbiter #(.NUM_REQ(N), .DATA_W(W), .FMUL_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(ready[k]),
      .req_op1(req_op1), .req_op2(req_op2), .req_opc(req_opc), .req_rmode(req_rmode),
      .fm_op1(fm_op1[k]), .fm_op2(fm_op2[k]), .fm_opc(fm_opc[k]), .fm_rmode(fm_rmode[k]),
      .fm_result(fm_result[k]), .fm_val(fm_val[k]),
      .rsp_valid(rsp_valid[k]), .rsp_result(rsp_result[k]), .rsp_val(rsp_val[k]),
      .busy(busy[k])
    );

    always_ff @(posedge clk) begin
      pr[0] <= fmul_ref(fm_op1[k], fm_op2[k], fm_opc[k], fm_rmode[k]);
      pv[0] <= (fm_opc[k] != 2'd3);
      for (int s = 1; s < L; s++) begin
        pr[s] <= pr[s-1];
        pv[s] <= pv[s-1];
      end
    end
    assign fm_result[k] = pr[L-1];
    assign fm_val[k]    = pv[L-1];
  end

  // Requester-side state
  logic        rv [N];
  logic [31:0] ra [N], rb [N];
  logic [1:0]  rc [N], rr [N];

  // Reference model: issue log indexed by the edge at which the handshake happened
  logic        iss_v   [MAXE];
  int          iss_id  [MAXE];
  logic [W-1:0] iss_res [MAXE];
  logic        iss_val [MAXE];
  int          edge_n;
  int          ptr;
  int          issued;
  logic [W-1:0] exp_f1, exp_f2;
  logic [1:0]  exp_fc, exp_fr;
  logic [W-1:0] exp_rres [NL];
  logic        exp_rval [NL];

  int total = 0;
  int bad   = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input int lat, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat=%0d t=%0t got=%h want=%h", name, lat, $time, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rv[i];
      req_op1[i*W +: W]  = ra[i];
      req_op2[i*W +: W]  = rb[i];
      req_opc[i*2 +: 2]  = rc[i];
      req_rmode[i*2 +: 2] = rr[i];
    end
  endtask

  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  // One clock: compare at the falling edge, then commit the handshake at the rising edge.
  task automatic cycle();
    int g;
    int t0;
    logic [N-1:0] exp_rv;
    logic eb;
    @(negedge clk);
    g = -1;
    if (en) begin
      for (int j = 0; j < N; j++) begin
        int i;
        i = (ptr + j) % N;
        if (g < 0 && rv[i]) g = i;
      end
    end
    for (int k = 0; k < NL; k++) begin
      t0 = edge_n - 1 - lat_of(k);
      exp_rv = '0;
      if (iss_v[t0]) begin
        exp_rv[iss_id[t0]] = 1'b1;
        exp_rres[k] = iss_res[t0];
        exp_rval[k] = iss_val[t0];
      end
      eb = 1'b0;
      for (int t = t0; t <= edge_n; t++) eb |= iss_v[t];
      chk("req_ready", lat_of(k), 64'(ready[k]), (g >= 0) ? 64'(1) << g : 64'd0);
      chk("rsp_valid", lat_of(k), 64'(rsp_valid[k]), 64'(exp_rv));
      chk("rsp_result", lat_of(k), 64'(rsp_result[k]), 64'(exp_rres[k]));
      chk("rsp_val", lat_of(k), 64'(rsp_val[k]), 64'(exp_rval[k]));
      chk("busy", lat_of(k), 64'(busy[k]), 64'(eb));
      chk("fm_op1", lat_of(k), 64'(fm_op1[k]), 64'(exp_f1));
      chk("fm_op2", lat_of(k), 64'(fm_op2[k]), 64'(exp_f2));
      chk("fm_opc", lat_of(k), 64'(fm_opc[k]), 64'(exp_fc));
      chk("fm_rmode", lat_of(k), 64'(fm_rmode[k]), 64'(exp_fr));
    end
    @(posedge clk);
    edge_n++;
    iss_v[edge_n] = 1'b0;
    if (g >= 0) begin
      iss_v[edge_n]   = 1'b1;
      iss_id[edge_n]  = g;
      iss_res[edge_n] = fmul_ref(ra[g], rb[g], rc[g], rr[g]);
      iss_val[edge_n] = (rc[g] != 2'd3);
      exp_f1 = ra[g];
      exp_f2 = rb[g];
      exp_fc = rc[g];
      exp_fr = rr[g];
      ptr = (g + 1) % N;
      rv[g] = 1'b0;
      issued++;
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NL; k++) begin
      chk("rst_ready", lat_of(k), 64'(ready[k]), 64'd0);
      chk("rst_rsp_valid", lat_of(k), 64'(rsp_valid[k]), 64'd0);
      chk("rst_rsp_result", lat_of(k), 64'(rsp_result[k]), 64'd0);
      chk("rst_rsp_val", lat_of(k), 64'(rsp_val[k]), 64'd0);
      chk("rst_busy", lat_of(k), 64'(busy[k]), 64'd0);
      chk("rst_fm_op1", lat_of(k), 64'(fm_op1[k]), 64'd0);
      chk("rst_fm_op2", lat_of(k), 64'(fm_op2[k]), 64'd0);
      chk("rst_fm_opc", lat_of(k), 64'(fm_opc[k]), 64'd0);
      chk("rst_fm_rmode", lat_of(k), 64'(fm_rmode[k]), 64'd0);
    end
    en = 1'b0;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    drive();
    for (int t = 0; t <= edge_n; t++) iss_v[t] = 1'b0;
    ptr = 0;
    exp_f1 = '0; exp_f2 = '0; exp_fc = '0; exp_fr = '0;
    for (int k = 0; k < NL; k++) begin
      exp_rres[k] = '0;
      exp_rval[k] = 1'b0;
    end
    repeat (2) begin
      @(posedge clk);
      edge_n++;
      iss_v[edge_n] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    edge_n++;
    iss_v[edge_n] = 1'b0;
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    rv[i] = 1'b1;
    ra[i] = a;
    rb[i] = b;
    rc[i] = 2'd0;
    rr[i] = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] prod [4];
    int base;
    int cyc;
    prod[0] = 32'h40400000; prod[1] = 32'h40C00000;
    prod[2] = 32'h41100000; prod[3] = 32'h41400000;
    for (int t = 0; t < MAXE; t++) iss_v[t] = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0; rr[i] = '0;
    end
    edge_n = 8;
    issued = 0;
    #2;
    do_reset();

    // Single op: 1.0 * 2.0
    en = 1'b1;
    set_req(0, 32'h3F800000, 32'h40000000);
    drive();
    #1;
    chk("single_ready", 2, 64'(ready[0]), 64'h1);
    for (int n = 0; n < 5; n++) begin
      cycle();
      if (n == 3) begin
        chk("single_rsp_valid", 2, 64'(rsp_valid[0]), 64'h1);
        chk("single_rsp_result", 2, 64'(rsp_result[0]), 64'h40000000);
      end
    end
    chk("single_busy_fall", 2, 64'(busy[0]), 64'd0);
    repeat (4) cycle();

    // All four at once: 3.0 * (1.0 + i)
    do_reset();
    en = 1'b1;
    set_req(0, 32'h40400000, 32'h3F800000);
    set_req(1, 32'h40400000, 32'h40000000);
    set_req(2, 32'h40400000, 32'h40400000);
    set_req(3, 32'h40400000, 32'h40800000);
    drive();
    for (int n = 0; n < 9; n++) begin
      if (n < 4) begin
        #1;
        chk("all4_grant", 2, 64'(ready[0]), 64'(1) << n);
      end
      cycle();
      if (n >= 3 && n <= 6) begin
        chk("all4_rsp_valid", 2, 64'(rsp_valid[0]), 64'(1) << (n - 3));
        chk("all4_rsp_result", 2, 64'(rsp_result[0]), 64'(prod[n-3]));
      end
    end

    // Rotation: after granting req1, pointer sits at 2
    do_reset();
    en = 1'b1;
    set_req(1, 32'h3F800000, 32'h3F800000);
    drive();
    cycle();
    set_req(0, 32'h40000000, 32'h40000000);
    set_req(3, 32'h40400000, 32'h40000000);
    drive();
    #1;
    chk("rot_first", 2, 64'(ready[0]), 64'h8);
    cycle();
    #1;
    chk("rot_second", 2, 64'(ready[0]), 64'h1);
    repeat (8) cycle();

    // en low with two ops in flight
    do_reset();
    en = 1'b1;
    set_req(0, 32'h3F800000, 32'h40400000);
    set_req(3, 32'h40000000, 32'h40800000);
    drive();
    repeat (2) cycle();
    en = 1'b0;
    set_req(1, 32'h40800000, 32'h40800000);
    set_req(2, 32'h40000000, 32'h3F800000);
    drive();
    #1;
    chk("en0_ready", 2, 64'(ready[0]), 64'd0);
    chk("en0_ready", 4, 64'(ready[1]), 64'd0);
    repeat (8) cycle();
    chk("en0_busy_drained", 2, 64'(busy[0]), 64'd0);
    chk("en0_busy_drained", 4, 64'(busy[1]), 64'd0);
    en = 1'b1;
    drive();
    #1;
    chk("en1_grant", 2, 64'(ready[0]), 64'h2);
    repeat (10) cycle();

    // Reset with three ops in flight
    do_reset();
    en = 1'b1;
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h40000000, 32'h3F800000);
    set_req(2, 32'h40400000, 32'h3F800000);
    drive();
    repeat (3) cycle();
    do_reset();
    en = 1'b1;
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(3, 32'h40800000, 32'h40000000);
    drive();
    #1;
    chk("post_rst_ptr0", 2, 64'(ready[0]), 64'h2);
    chk("post_rst_ptr0", 4, 64'(ready[1]), 64'h2);
    repeat (12) cycle();

    // Random traffic
    base = issued;
    cyc = 0;
    while (issued - base < 1000 && cyc < 6000) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) != 0) begin
          rv[i] = 1'b1;
          ra[i] = rnd_f();
          rb[i] = rnd_f();
          rc[i] = 2'($urandom);
          rr[i] = 2'($urandom);
        end
      end
      drive();
      cycle();
      cyc++;
    end
    chk("random_ops_issued", 0, 64'(issued - base >= 1000), 64'd1);
    en = 1'b0;
    drive();
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
